// File: rtl/program_counter_pkg.sv
// rtl/program_counter_pkg.sv - shared widths, op encoding and priority decode for program_counter
// Purpose: single home for the default PC width, return-stack depth and the
//          3-bit op code that program_counter resolves once per clock.
// Contents: PC_WIDTH, RSTACK_DEPTH, OP_* codes, decode_op() priority function.
package program_counter_pkg;

  localparam int PC_WIDTH     = 15;
  localparam int RSTACK_DEPTH = 8;

  localparam logic [2:0] OP_HOLD = 3'd0;
  localparam logic [2:0] OP_INC  = 3'd1;
  localparam logic [2:0] OP_LOAD = 3'd2;
  localparam logic [2:0] OP_CALL = 3'd3;
  localparam logic [2:0] OP_RET  = 3'd4;
  localparam logic [2:0] OP_ERR  = 3'd5;

  // Priority: call&ret > ret > call > load > inc > hold. Stack under/overflow
  // collapses into OP_ERR here so the datapath never sees an unsafe push/pop.
  function automatic logic [2:0] decode_op(
    input logic load,
    input logic inc,
    input logic call,
    input logic ret,
    input logic full,
    input logic empty
  );
    logic [2:0] op;
    op = OP_HOLD;
    if (call && ret)  op = OP_ERR;
    else if (ret)     op = empty ? OP_ERR : OP_RET;
    else if (call)    op = full ? OP_ERR : OP_CALL;
    else if (load)    op = OP_LOAD;
    else if (inc)     op = OP_INC;
    return op;
  endfunction

endpackage

// File: rtl/program_counter_ret_stack.sv
// rtl/program_counter_ret_stack.sv - LIFO return-address stack for program_counter
// Purpose: DEPTH-entry stack of WIDTH-bit return addresses. Only the occupancy
//          counter is reset; entry storage is plain RAM whose contents above sp
//          are unreachable.
// Ports:
//   clk            clock, rising edge
//   rst_n          synchronous active-low reset (clears sp only)
//   push / pop     write din at sp / drop top entry (never both from the owner)
//   din            address to push
//   dout           current top entry (stack[sp-1]), meaningless while empty
//   sp             occupancy 0..DEPTH
//   full / empty   sp == DEPTH / sp == 0
module ret_stack
  import program_counter_pkg::*;
#(
  parameter  int WIDTH = PC_WIDTH,
  parameter  int DEPTH = RSTACK_DEPTH,
  localparam int SPW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [SPW-1:0]   sp,
  output logic             full,
  output logic             empty
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [SPW-1:0]   r_sp;
  logic [IW-1:0]    w_rd_idx;
  logic [IW-1:0]    w_wr_idx;

  // Top read is driven from the registered sp, so a pop sees the entry that
  // was current before the edge.
  assign w_rd_idx = IW'(r_sp - SPW'(1));
  assign w_wr_idx = IW'(r_sp);

  assign dout  = r_mem[w_rd_idx];
  assign sp    = r_sp;
  assign full  = (r_sp == SPW'(DEPTH));
  assign empty = (r_sp == '0);

  always_ff @(posedge clk) begin
    if (push && !full) begin
      r_mem[w_wr_idx] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sp <= '0;
    end else if (push && !full) begin
      r_sp <= r_sp + SPW'(1);
    end else if (pop && !empty) begin
      r_sp <= r_sp - SPW'(1);
    end
  end

endmodule

// File: rtl/program_counter.sv
// rtl/program_counter.sv - LittleComputer program counter with call/ret stack, wrap and error flags
// Purpose: registered PC with load/inc/call/ret, hardware return stack,
//          one-cycle wrap pulse and sticky illegal-op flag.
// Ports:
//   clk, rst_n     clock / synchronous active-low reset
//   load, inc      pc <= target / pc <= pc+1
//   call, ret      push pc+1 and jump to target / pop into pc
//   target         jump or call destination
//   pc             current program counter
//   sp             return-stack occupancy 0..DEPTH
//   stack_full     sp == DEPTH
//   stack_empty    sp == 0
//   wrapped        pulse: the last inc or call push went all-ones -> 0
//   err            sticky illegal op (call&ret, ret empty, call full)
module program_counter
  import program_counter_pkg::*;
#(
  parameter  int WIDTH = PC_WIDTH,
  parameter  int DEPTH = RSTACK_DEPTH,
  localparam int SPW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             inc,
  input  logic             call,
  input  logic             ret,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] pc,
  output logic [SPW-1:0]   sp,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             wrapped,
  output logic             err
);

  logic [WIDTH-1:0] r_pc;
  logic             r_wrapped;
  logic             r_err;

  logic [2:0]       w_op;
  logic [WIDTH-1:0] w_pc_inc;
  logic             w_carry;
  logic [WIDTH-1:0] w_stack_dout;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  // Carry out of the WIDTH-bit increment is exactly the wrap condition.
  assign {w_carry, w_pc_inc} = {1'b0, r_pc} + {{WIDTH{1'b0}}, 1'b1};

  assign w_op   = decode_op(load, inc, call, ret, w_full, w_empty);
  assign w_push = (w_op == OP_CALL);
  assign w_pop  = (w_op == OP_RET);

  ret_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ret_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_pc_inc),
    .dout  (w_stack_dout),
    .sp    (sp),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc      <= '0;
      r_wrapped <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_wrapped <= 1'b0;
      unique case (w_op)
        OP_ERR:  r_err <= 1'b1;
        OP_RET:  r_pc  <= w_stack_dout;
        OP_CALL: begin
          r_pc      <= target;
          r_wrapped <= w_carry;
        end
        OP_LOAD: r_pc <= target;
        OP_INC: begin
          r_pc      <= w_pc_inc;
          r_wrapped <= w_carry;
        end
        default: r_pc <= r_pc;
      endcase
    end
  end

  assign pc          = r_pc;
  assign wrapped     = r_wrapped;
  assign err         = r_err;
  assign stack_full  = w_full;
  assign stack_empty = w_empty;

endmodule

// File: tb/tb_program_counter.sv
// tb/tb_program_counter.sv - randomized self-checking bench for program_counter
module tb_program_counter;

  localparam int W     = 15;
  localparam int D     = 8;
  localparam int SPW   = $clog2(D + 1);
  localparam int PCMAX = (1 << W) - 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           load = 1'b0;
  logic           inc = 1'b0;
  logic           call = 1'b0;
  logic           ret = 1'b0;
  logic [W-1:0]   target = '0;
  logic [W-1:0]   pc;
  logic [SPW-1:0] sp;
  logic           stack_full;
  logic           stack_empty;
  logic           wrapped;
  logic           err;

  program_counter #(.WIDTH(W), .DEPTH(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .inc         (inc),
    .call        (call),
    .ret         (ret),
    .target      (target),
    .pc          (pc),
    .sp          (sp),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .wrapped     (wrapped),
    .err         (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Reference model: plain integers and a queue as the return stack.
  int m_pc = 0;
  int m_stk[$];
  bit m_wrapped = 1'b0;
  bit m_err = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit rn, input bit ld, input bit ic,
                            input bit cl, input bit rt, input int tg);
    if (!rn) begin
      m_pc = 0;
      m_stk.delete();
      m_wrapped = 0;
      m_err = 0;
    end else begin
      m_wrapped = 0;
      if (cl && rt) begin
        m_err = 1;
      end else if (rt) begin
        if (m_stk.size() == 0) m_err = 1;
        else m_pc = m_stk.pop_back();
      end else if (cl) begin
        if (m_stk.size() == D) begin
          m_err = 1;
        end else begin
          m_stk.push_back((m_pc + 1) % (PCMAX + 1));
          m_wrapped = (m_pc == PCMAX);
          m_pc = tg;
        end
      end else if (ld) begin
        m_pc = tg;
      end else if (ic) begin
        m_wrapped = (m_pc == PCMAX);
        m_pc = (m_pc + 1) % (PCMAX + 1);
      end
    end
  endtask

  task automatic step(input bit rn, input bit ld, input bit ic,
                      input bit cl, input bit rt, input int tg);
    rst_n  = rn;
    load   = ld;
    inc    = ic;
    call   = cl;
    ret    = rt;
    target = tg[W-1:0];
    @(posedge clk);
    #1;
    model_edge(rn, ld, ic, cl, rt, tg & PCMAX);
    chk_en = 1'b1;
  endtask

  // Single compare process: every negedge once the model is established.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc",          int'(pc),          m_pc);
      chk("sp",          int'(sp),          m_stk.size());
      chk("stack_full",  int'(stack_full),  int'(m_stk.size() == D));
      chk("stack_empty", int'(stack_empty), int'(m_stk.size() == 0));
      chk("wrapped",     int'(wrapped),     int'(m_wrapped));
      chk("err",         int'(err),         int'(m_err));
    end
  end

  initial begin
    int r;
    int tg;
    bit ld;
    bit ic;

    // Reset held two cycles with inc asserted
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("lit_reset_pc", int'(pc), 0);
    chk("lit_reset_sp", int'(sp), 0);
    chk("lit_reset_err", int'(err), 0);
    chk("lit_reset_wrapped", int'(wrapped), 0);

    // Inc / load
    repeat (3) step(1, 0, 1, 0, 0, 0);
    chk("lit_inc3", int'(pc), 3);
    step(1, 1, 0, 0, 0, 'h1234);
    chk("lit_load", int'(pc), 'h1234);
    step(1, 1, 1, 0, 0, 5);
    chk("lit_load_inc", int'(pc), 5);

    // Wrap
    step(1, 1, 0, 0, 0, 'h7FFF);
    step(1, 0, 1, 0, 0, 0);
    chk("lit_wrap_pc", int'(pc), 0);
    chk("lit_wrap_pulse", int'(wrapped), 1);
    step(1, 0, 1, 0, 0, 0);
    chk("lit_wrap_next_pc", int'(pc), 1);
    chk("lit_wrap_clear", int'(wrapped), 0);

    // Nesting
    step(1, 1, 0, 0, 0, 'h10);
    step(1, 0, 0, 1, 0, 'h100);
    step(1, 0, 0, 1, 0, 'h200);
    chk("lit_nest_sp", int'(sp), 2);
    step(1, 0, 0, 0, 1, 0);
    chk("lit_ret1_pc", int'(pc), 'h101);
    chk("lit_ret1_sp", int'(sp), 1);
    step(1, 0, 0, 0, 1, 0);
    chk("lit_ret2_pc", int'(pc), 'h11);
    chk("lit_ret2_sp", int'(sp), 0);

    // Bounds: pc=0, then calls to 0x100+i push 1, 0x101 .. 0x107
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < D; i++) step(1, 0, 0, 1, 0, 'h100 + i);
    chk("lit_full", int'(stack_full), 1);
    step(1, 0, 0, 1, 0, 'h55);
    chk("lit_ovf_err", int'(err), 1);
    chk("lit_ovf_pc", int'(pc), 'h107);
    chk("lit_ovf_sp", int'(sp), D);
    for (int k = 0; k < D; k++) begin
      step(1, 0, 0, 0, 1, 0);
      chk("lit_lifo", int'(pc), (k == D - 1) ? 1 : ('h107 - k));
    end
    step(1, 0, 0, 0, 1, 0);
    chk("lit_unf_err", int'(err), 1);
    chk("lit_unf_pc", int'(pc), 1);

    // Conflict and reset mid-stack
    step(0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 'h40);
    step(1, 0, 0, 1, 1, 'h99);
    chk("lit_conflict_err", int'(err), 1);
    chk("lit_conflict_pc", int'(pc), 'h40);
    repeat (3) step(1, 0, 0, 1, 0, 'h300);
    chk("lit_mid_sp", int'(sp), 3);
    step(0, 0, 0, 0, 0, 0);
    chk("lit_rst_sp", int'(sp), 0);
    chk("lit_rst_pc", int'(pc), 0);
    chk("lit_rst_err", int'(err), 0);
    step(1, 0, 0, 0, 1, 0);
    chk("lit_rst_ret_err", int'(err), 1);

    // Call from all-ones pushes 0 and pulses wrapped
    step(0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 'h7FFF);
    step(1, 0, 0, 1, 0, 'h20);
    chk("lit_call_wrap", int'(wrapped), 1);
    step(1, 0, 0, 0, 1, 0);
    chk("lit_call_wrap_ret", int'(pc), 0);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      r  = $urandom_range(0, 99);
      tg = ($urandom_range(0, 7) == 0) ? PCMAX : int'($urandom_range(0, PCMAX));
      ld = $urandom_range(0, 3) == 0;
      ic = $urandom_range(0, 1) == 1;
      if (r < 2)       step(0, ld, ic, 0, 0, tg);
      else if (r < 5)  step(1, ld, ic, 1, 1, tg);
      else if (r < 27) step(1, ld, ic, 0, 1, tg);
      else if (r < 50) step(1, ld, ic, 1, 0, tg);
      else if (r < 62) step(1, 1, ic, 0, 0, tg);
      else if (r < 95) step(1, 0, 1, 0, 0, tg);
      else             step(1, 0, 0, 0, 0, tg);
    end

    @(negedge clk);
    chk_en = 1'b0;
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
